// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings and field widths.
package led_pattern_gen_pkg;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4
    } mode_e;

    localparam int unsigned CH_W   = 4;   // width of the channel index
    localparam int unsigned PWM_W  = 8;   // width of PWM counter and duty
    localparam int unsigned ARG_W  = 16;  // width of the configuration argument
    localparam int unsigned MODE_W = 3;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its configuration and pattern state, produces the unregistered lit level.
module led_channel
    import led_pattern_gen_pkg::*;
#(
    parameter int unsigned DEFAULT_PERIOD = 250
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              tick,
    input  logic [PWM_W-1:0]  pwm_cnt,
    input  logic              load,
    input  logic [MODE_W-1:0] mode,
    input  logic [ARG_W-1:0]  arg,
    output logic              lit
);

    logic [MODE_W-1:0] mode_q;
    logic [ARG_W-1:0]  arg_q;
    logic [ARG_W-1:0]  phase_q;
    logic [PWM_W-1:0]  duty_q;
    logic              down_q;
    logic              blink_q;
    logic [ARG_W-1:0]  phase_last;

    // An argument of zero blinks like an argument of one.
    assign phase_last = (arg_q == '0) ? '0 : arg_q - ARG_W'(1);

    // Configuration load takes priority over a coincident tick; ticks advance the active pattern.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q  <= MODE_BLINK;
            arg_q   <= ARG_W'(DEFAULT_PERIOD);
            phase_q <= '0;
            duty_q  <= '0;
            down_q  <= 1'b0;
            blink_q <= 1'b0;
        end else if (load) begin
            mode_q  <= mode;
            arg_q   <= arg;
            phase_q <= '0;
            duty_q  <= '0;
            down_q  <= 1'b0;
            blink_q <= 1'b0;
        end else if (tick) begin
            if (mode_q == MODE_BLINK) begin
                if (phase_q == phase_last) begin
                    blink_q <= ~blink_q;
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_q + ARG_W'(1);
                end
            end
            if (mode_q == MODE_BREATHE) begin
                // Turn around as soon as an end point is reached so each end is held one tick.
                if (!down_q) begin
                    duty_q <= duty_q + PWM_W'(1);
                    if (duty_q == PWM_W'(254)) down_q <= 1'b1;
                end else begin
                    duty_q <= duty_q - PWM_W'(1);
                    if (duty_q == PWM_W'(1)) down_q <= 1'b0;
                end
            end
        end
    end

    // Decode the current mode into the lit level; unused encodings are dark.
    always_comb begin
        lit = 1'b0;
        case (mode_q)
            MODE_ON:      lit = 1'b1;
            MODE_BLINK:   lit = blink_q;
            MODE_PWM:     lit = (pwm_cnt < arg_q[PWM_W-1:0]);
            MODE_BREATHE: lit = (pwm_cnt < duty_q);
            default:      lit = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: prescaler, shared PWM base, config decode, output register.
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int unsigned N_LEDS         = 2,
    parameter int unsigned PRESCALE       = 50000,
    parameter int unsigned DEFAULT_PERIOD = 250,
    parameter bit          ACTIVE_LOW     = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [MODE_W-1:0] CFG_MODE,
    input  logic [ARG_W-1:0]  CFG_ARG,
    output logic [N_LEDS-1:0] LED,
    output logic              TICK
);

    localparam int unsigned    PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]   ps_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              ready_q;
    logic [N_LEDS-1:0] load;
    logic [N_LEDS-1:0] lit;

    // Gating with ready keeps TICK low during reset even when PRESCALE is 1.
    assign TICK      = ready_q & (ps_cnt == PS_LAST);
    assign CFG_READY = ready_q;

    // Tick prescaler, wraps at PRESCALE-1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps_cnt <= '0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    // Free-running PWM base shared by all channels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // Ready rises on the first edge after reset release and stays high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Channel-select decode; out-of-range indices hit no channel.
    always_comb begin
        load = '0;
        for (int i = 0; i < int'(N_LEDS); i++) begin
            load[i] = CFG_VALID & ready_q & (CFG_CH == CH_W'(i));
        end
    end

    for (genvar g = 0; g < int'(N_LEDS); g++) begin : g_ch
        led_channel #(
            .DEFAULT_PERIOD(DEFAULT_PERIOD)
        ) u_ch (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .tick   (TICK),
            .pwm_cnt(pwm_cnt),
            .load   (load[g]),
            .mode   (CFG_MODE),
            .arg    (CFG_ARG),
            .lit    (lit[g])
        );
    end

    // Registered, polarity-corrected LED pins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LED <= {N_LEDS{ACTIVE_LOW}};
        end else begin
            LED <= lit ^ {N_LEDS{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: two active-low channels, 4-cycle tick, 3-tick default blink.
module tb_led_pattern_gen;
    import led_pattern_gen_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic [3:0]  CFG_CH;
    logic [2:0]  CFG_MODE;
    logic [15:0] CFG_ARG;
    logic [1:0]  LED;
    logic        TICK;

    int total = 0;
    int bad   = 0;
    int k     = 0;  // clock edges since reset release

    led_pattern_gen #(
        .N_LEDS        (2),
        .PRESCALE      (4),
        .DEFAULT_PERIOD(3),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CFG_VALID(CFG_VALID),
        .CFG_READY(CFG_READY),
        .CFG_CH   (CFG_CH),
        .CFG_MODE (CFG_MODE),
        .CFG_ARG  (CFG_ARG),
        .LED      (LED),
        .TICK     (TICK)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        k++;
    endtask

    // One transfer; afterwards the inputs hold junk that must be ignored with VALID low.
    task automatic cfg(input logic [3:0] ch, input logic [2:0] mode, input logic [15:0] arg,
                       output int t);
        CFG_VALID = 1'b1;
        CFG_CH    = ch;
        CFG_MODE  = mode;
        CFG_ARG   = arg;
        step();
        t         = k;
        CFG_VALID = 1'b0;
        CFG_CH    = 4'd0;
        CFG_MODE  = 3'd1;
        CFG_ARG   = 16'hffff;
    endtask

    // Untouched default channel: toggles on every 12th edge, LED follows one edge later.
    function automatic bit blink0_lit(input int kk);
        return (((kk - 1) / 12) % 2) == 1;
    endfunction

    // Triangle of the breathe duty after n ticks.
    function automatic int tri_duty(input int n);
        int m;
        m = n % 510;
        return (m <= 255) ? m : 510 - m;
    endfunction

    initial begin
        int t;
        int cnt;
        int mis;
        int n;
        bit l;

        RST_N     = 1'b0;
        CFG_VALID = 1'b0;
        CFG_CH    = 4'd0;
        CFG_MODE  = 3'd0;
        CFG_ARG   = 16'd0;
        repeat (3) @(negedge CLK);
        check_eq("rst_led", LED, 2'b11);
        check_eq("rst_ready", CFG_READY, 0);
        check_eq("rst_tick", TICK, 0);

        RST_N = 1'b1;
        k     = 0;
        #1 check_eq("ready_before_edge", CFG_READY, 0);

        // Tick cadence and default blink of both channels in phase.
        for (int i = 0; i < 40; i++) begin
            step();
            if (k == 1) check_eq("ready_after_edge", CFG_READY, 1);
            check_eq("tick", TICK, (k % 4) == 3);
            check_eq("blink_default", LED, blink0_lit(k) ? 2'b00 : 2'b11);
        end

        // PWM duty 64 on ch1, ch0 must keep blinking.
        cfg(4'd1, MODE_PWM, 16'd64, t);
        cnt = 0;
        mis = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (LED[1] == 1'b0) cnt++;
            if (LED[0] !== !blink0_lit(k)) mis++;
        end
        check_eq("pwm64_lit_count", cnt, 64);
        check_eq("pwm64_ch0_blink", mis, 0);

        // PWM duty 0 is never lit.
        cfg(4'd1, MODE_PWM, 16'd0, t);
        cnt = 0;
        mis = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (LED[1] == 1'b0) cnt++;
            if (LED[0] !== !blink0_lit(k)) mis++;
        end
        check_eq("pwm0_lit_count", cnt, 0);
        check_eq("pwm0_ch0_blink", mis, 0);

        // Out-of-range channel is accepted with no effect.
        cfg(4'd5, MODE_ON, 16'd0, t);
        check_eq("ch5_ready", CFG_READY, 1);
        mis = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (LED !== {1'b1, !blink0_lit(k)}) mis++;
        end
        check_eq("ch5_no_effect", mis, 0);

        // BLINK with arg 0 toggles on every tick.
        cfg(4'd1, MODE_BLINK, 16'd0, t);
        mis = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            n = (k - 1) / 4 - t / 4;
            if (LED[1] !== !(n % 2 == 1)) mis++;
            if (LED[0] !== !blink0_lit(k)) mis++;
        end
        check_eq("blink_arg0", mis, 0);

        // Reconfigure ch0 on a tick edge: the tick is dropped, first toggle 2 ticks later.
        while (((k + 1) % 4) != 0) step();
        check_eq("tick_before_cfg", TICK, 1);
        cfg(4'd0, MODE_BLINK, 16'd2, t);
        mis = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (LED[0] !== !((((k - 1 - t) / 8) % 2) == 1)) mis++;
        end
        check_eq("cfg_on_tick", mis, 0);

        // Breathe on ch0 over a full triangle, ch1 held on.
        cfg(4'd1, MODE_ON, 16'd0, t);
        cfg(4'd0, MODE_BREATHE, 16'habcd, t);
        mis = 0;
        for (int i = 0; i < 2100; i++) begin
            step();
            n = (k - 1) / 4 - t / 4;
            l = ((k - 1) % 256) < tri_duty(n);
            if (LED !== {1'b0, !l}) mis++;
        end
        check_eq("breathe", mis, 0);

        // Reset mid-breathe darkens the LEDs at once.
        #2 RST_N = 1'b0;
        #1;
        check_eq("midrst_led", LED, 2'b11);
        check_eq("midrst_ready", CFG_READY, 0);
        check_eq("midrst_tick", TICK, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_eq("postrst_ready", CFG_READY, 1);
        check_eq("postrst_led", LED, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised, multi-channel successor to the board's free-running LED blinker.
- Each LED channel runs independently in one of five modes: OFF, ON, BLINK with programmable half-period, fixed-duty PWM, or BREATHE (triangular duty ramp).
- Channels are configured at run time through a valid/ready port driven by a UART/SPI register block or a test harness.
- Sits at the top level of every board design, directly driving the LED pins.

Parameters:
- N_LEDS, 2, number of independent LED channels (1..16)
- PRESCALE, 50000, CLK cycles per tick (>=1); ticks time BLINK and BREATHE
- DEFAULT_PERIOD, 250, BLINK half-period in ticks loaded at reset
- ACTIVE_LOW, 0, 1 = LED pin driven 0 when lit

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset; deassertion synchronous to CLK upstream
- CFG_VALID  in  1  configuration request
- CFG_READY  out  1  block can accept configuration
- CFG_CH  in  4  target channel index
- CFG_MODE  in  3  0=OFF 1=ON 2=BLINK 3=PWM 4=BREATHE, 5..7 = OFF
- CFG_ARG  in  16  BLINK: half-period in ticks; PWM: duty in [7:0]; ignored otherwise
- LED  out  N_LEDS  LED pins, registered
- TICK  out  1  one-cycle prescaler strobe, for debug/test

Behaviour:
- Reset (RST_N low, async):
  - all channels mode=BLINK, arg=DEFAULT_PERIOD, internal counters 0
  - LED = unlit level (all 0, or all 1 if ACTIVE_LOW)
  - CFG_READY=0, TICK=0
- Prescaler:
  - counter 0..PRESCALE-1, wraps to 0
  - TICK high for exactly the one cycle in which the counter = PRESCALE-1
  - PRESCALE=1 gives TICK high every cycle
- PWM base:
  - shared 8-bit counter pwm_cnt increments every CLK and wraps 255->0
  - lit when pwm_cnt < duty; duty 0 = never lit, 255 = lit 255/256 (full on is mode ON)
- Per-channel modes:
  - OFF/ON: constant unlit/lit.
  - BLINK:
    - 16-bit phase counter increments on TICK
    - when phase = max(arg,1)-1 on a TICK: toggle the blink state and clear phase
    - arg=0 behaves as arg=1
    - blink state starts unlit after reset or reconfiguration
  - PWM: duty = arg[7:0].
  - BREATHE:
    - 8-bit duty steps by 1 per TICK, starting at 0, direction up
    - reaches 255 -> next step 254 (direction down); reaches 0 -> next step 1 (up)
    - full cycle = 510 ticks
- Config handshake:
  - CFG_READY=1 every cycle after the first CLK edge following reset release; never throttles
  - transfer occurs on a CLK edge with CFG_VALID & CFG_READY
  - on that edge the channel's mode and arg are written and its phase/duty/blink/direction state is cleared
  - CFG_CH >= N_LEDS: accepted, no effect
  - transfer on the same edge as a TICK for that channel: configuration wins; the tick is not applied to that channel
  - CFG_* inputs are ignored when CFG_VALID=0
- Latency: LED reflects the new mode on the edge after the transfer edge (1 cycle); mode-dependent state advances from the next TICK.
- Output: LED[i] = lit XOR ACTIVE_LOW, registered, glitch-free.
- Reset mid-operation immediately returns to the reset state; no partial configuration survives.

Decomposition:
- Shared package: mode encodings (MODE_OFF..MODE_BREATHE), CFG_CH width 4, PWM width 8.
- Sub-module led_channel: holds mode/arg/phase/duty/direction/blink state. Inputs: tick, pwm_cnt, load strobe, mode, arg. Output: lit.
- Top level: prescaler, pwm_cnt, channel-select decode, N_LEDS generate instances, output polarity register.

Test Plan:
- Reset: PRESCALE=4, ACTIVE_LOW=1, hold RST_N low -> LED=2'b11, CFG_READY=0. Release -> CFG_READY=1 after 1 edge; TICK every 4th cycle.
- Default blink: DEFAULT_PERIOD=3, PRESCALE=4, no config -> each LED toggles every 12 cycles, first lit 12 cycles after reset release, both channels in phase.
- PWM: ch1 MODE=3 ARG=64 -> LED[1] lit exactly 64 of every 256 cycles. ARG=0 -> never lit. LED[0] BLINK unaffected.
- Breathe: ch0 MODE=4 -> duty 0,1..255,254..0 over 510 ticks; duty at tick 300 = 210; lit-count per 256-cycle window matches duty.
- Edge cases:
  - CFG_CH=5 with N_LEDS=2 -> accepted, LEDs unchanged
  - BLINK ARG=0 -> toggles every tick
  - config on a TICK edge -> phase 0, no toggle
  - reset asserted mid-BREATHE -> LEDs unlit on the same cycle
